// File: rtl/pipeline_sequencer_pkg.sv
// pipeline_sequencer_pkg
//   Shared definitions for the fetch/decode/execute sequencer: the state
//   encoding (also exported on the debug state port), default widths and the
//   NOP word (MOV R0,R0) that fills the fetch/decode register on reset or flush.
package pipeline_sequencer_pkg;

    localparam int                 DEFAULT_INSTR_W = 32;
    localparam int                 DEFAULT_EXEC_W  = 2;
    localparam logic [31:0]        DEFAULT_NOP     = 32'hE1A0_0000;

    // Encoding is visible to software/debug, so the values are fixed.
    typedef enum logic [1:0] {
        ST_RST    = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DECODE = 2'd2,
        ST_EXEC   = 2'd3
    } seqState_t;

endpackage

// File: rtl/pipeline_sequencer_if.sv
// pipeline_sequencer_if
//   Groups the instruction-memory handshake and the decoder-facing signals of
//   the sequencer.
//   master (sequencer): drives imem_req, fd_instruction, fd_valid;
//                       reads imem_valid, imem_data, dec_exec_cycles, dec_writes_pc.
//   slave  (memory/decoder side): the reverse directions.
interface pipeline_sequencer_if
    import pipeline_sequencer_pkg::*;
#(
    parameter int INSTR_W = DEFAULT_INSTR_W,
    parameter int EXEC_W  = DEFAULT_EXEC_W
);
    logic               imem_req;
    logic               imem_valid;
    logic [INSTR_W-1:0] imem_data;
    logic [INSTR_W-1:0] fd_instruction;
    logic               fd_valid;
    logic [EXEC_W-1:0]  dec_exec_cycles;
    logic               dec_writes_pc;

    modport master (
        output imem_req,
        output fd_instruction,
        output fd_valid,
        input  imem_valid,
        input  imem_data,
        input  dec_exec_cycles,
        input  dec_writes_pc
    );

    modport slave (
        input  imem_req,
        input  fd_instruction,
        input  fd_valid,
        output imem_valid,
        output imem_data,
        output dec_exec_cycles,
        output dec_writes_pc
    );
endinterface

// File: rtl/pipeline_sequencer_exec_cycle_counter.sv
// pipeline_sequencer_exec_cycle_counter
//   Execute-phase cycle counter. A load restarts the count at 0 and captures
//   the instruction length (cycles minus 1); enable advances the count, which
//   saturates at the length so it never wraps.
//   Ports: clk, reset (sync, active-low), i_load, i_enable, i_len,
//          o_count (current 0-based cycle), o_last (count has reached length).
module pipeline_sequencer_exec_cycle_counter #(
    parameter int EXEC_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_enable,
    input  logic [EXEC_W-1:0] i_len,
    output logic [EXEC_W-1:0] o_count,
    output logic              o_last
);
    logic [EXEC_W-1:0] r_count;
    logic [EXEC_W-1:0] r_len;
    logic              w_last;

    assign w_last  = (r_count == r_len);
    assign o_count = r_count;
    assign o_last  = w_last;

    // Load wins over enable; counting stops once the last cycle is reached.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
            r_len   <= '0;
        end else if (i_load) begin
            r_count <= '0;
            r_len   <= i_len;
        end else if (i_enable && !w_last) begin
            r_count <= r_count + EXEC_W'(1);
        end
    end
endmodule

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer
//   Fetch/decode/execute sequencer between instruction memory and decoder.
//   Generates the phase strobes the control registers latch on, supports
//   fetch wait states, variable-length execute, external stall, optional
//   overlapped fetch in the last execute cycle, and flush on PC writes.
//   Ports:
//     clk, reset            clock; synchronous active-low reset
//     i_stall               freeze sequencer this cycle (ignored in RST)
//     io_bus (master)       imem handshake, fd register, decoder inputs
//     o_pc_inc_en           instruction accepted, PC increments this edge
//     o_decode_latch        control registers latch decoder outputs
//     o_exec_active         execute phase in progress
//     o_exec_cycle_idx      0-based execute cycle
//     o_exec_last           final execute cycle
//     o_flush               PC-writing instruction completing
//     o_control_reset       reset strobe to datapath
//     o_state               debug state (RST/FETCH/DECODE/EXEC)
module pipeline_sequencer
    import pipeline_sequencer_pkg::*;
#(
    parameter int          INSTR_W      = DEFAULT_INSTR_W,
    parameter int          EXEC_W       = DEFAULT_EXEC_W,
    parameter int          RESET_CYCLES = 2,
    parameter logic [31:0] NOP_INSTR    = DEFAULT_NOP,
    parameter int          PIPELINED    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_stall,
    pipeline_sequencer_if.master  io_bus,
    output logic                  o_pc_inc_en,
    output logic                  o_decode_latch,
    output logic                  o_exec_active,
    output logic [EXEC_W-1:0]     o_exec_cycle_idx,
    output logic                  o_exec_last,
    output logic                  o_flush,
    output logic                  o_control_reset,
    output logic [1:0]            o_state
);
    localparam int RST_CNT_W = $clog2(RESET_CYCLES + 1);
    localparam logic [RST_CNT_W-1:0] RST_LAST = RST_CNT_W'(RESET_CYCLES - 1);

    seqState_t            r_state;
    seqState_t            w_nextState;
    logic [RST_CNT_W-1:0] r_rstCnt;
    logic [INSTR_W-1:0]   r_fdInstr;
    logic                 r_fdValid;
    logic                 r_exWpc;

    logic [EXEC_W-1:0]    w_exCnt;
    logic                 w_exLast;
    logic                 w_inExec;
    logic                 w_lastGo;
    logic                 w_overlapSlot;
    logic                 w_capture;
    logic                 w_decodeLoad;
    logic                 w_flush;
    logic                 w_imemReq;

    assign w_inExec = (r_state == ST_EXEC);

    // Last execute cycle, not stalled: the instruction retires this edge.
    assign w_lastGo = w_inExec && w_exLast && !i_stall;

    // Overlapped fetch is only offered when the retiring instruction does not
    // write the PC; a pending flush always wins.
    assign w_overlapSlot = w_inExec && w_exLast && !r_exWpc && (PIPELINED != 0);

    // An instruction word is accepted either in FETCH or in the overlap slot.
    assign w_capture = !i_stall && io_bus.imem_valid &&
                       ((r_state == ST_FETCH) || w_overlapSlot);

    assign w_decodeLoad = (r_state == ST_DECODE) && !i_stall;
    assign w_flush      = w_lastGo && r_exWpc;

    pipeline_sequencer_exec_cycle_counter #(
        .EXEC_W (EXEC_W)
    ) u_execCounter (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_decodeLoad),
        .i_enable (w_inExec && !i_stall),
        .i_len    (io_bus.dec_exec_cycles),
        .o_count  (w_exCnt),
        .o_last   (w_exLast)
    );

    // State register; reset forces RST regardless of any other condition.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_RST;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Reset-release counter: holds the FSM in RST for RESET_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rstCnt <= '0;
        end else if (r_state == ST_RST && r_rstCnt != RST_LAST) begin
            r_rstCnt <= r_rstCnt + RST_CNT_W'(1);
        end
    end

    // Fetch/decode register: loaded on an accepted word, cleared to NOP on flush.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fdInstr <= NOP_INSTR[INSTR_W-1:0];
            r_fdValid <= 1'b0;
            r_exWpc   <= 1'b0;
        end else begin
            if (w_capture) begin
                r_fdInstr <= io_bus.imem_data;
                r_fdValid <= 1'b1;
            end else if (w_flush) begin
                r_fdInstr <= NOP_INSTR[INSTR_W-1:0];
                r_fdValid <= 1'b0;
            end
            if (w_decodeLoad) begin
                r_exWpc <= io_bus.dec_writes_pc;
            end
        end
    end

    // Next-state logic; stall holds FETCH/DECODE/EXEC but not RST.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_RST: begin
                if (r_rstCnt == RST_LAST) begin
                    w_nextState = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (io_bus.imem_valid && !i_stall) begin
                    w_nextState = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (!i_stall) begin
                    w_nextState = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (w_lastGo) begin
                    if (!r_exWpc && (PIPELINED != 0) && io_bus.imem_valid) begin
                        w_nextState = ST_DECODE;
                    end else begin
                        w_nextState = ST_FETCH;
                    end
                end
            end
            default: w_nextState = ST_RST;
        endcase
    end

    // Moore-style output decode, qualified by stall and imem_valid; stall
    // masks the edge strobes but leaves the fetch request as the state asks.
    always_comb begin
        w_imemReq        = 1'b0;
        o_pc_inc_en      = 1'b0;
        o_decode_latch   = 1'b0;
        o_exec_active    = 1'b0;
        o_exec_cycle_idx = '0;
        o_exec_last      = 1'b0;
        o_flush          = 1'b0;
        o_control_reset  = 1'b0;
        case (r_state)
            ST_RST: begin
                o_control_reset = 1'b1;
            end
            ST_FETCH: begin
                w_imemReq   = 1'b1;
                o_pc_inc_en = w_capture;
            end
            ST_DECODE: begin
                o_decode_latch = w_decodeLoad;
            end
            ST_EXEC: begin
                o_exec_active    = 1'b1;
                o_exec_cycle_idx = w_exCnt;
                o_exec_last      = w_exLast;
                o_flush          = w_flush;
                w_imemReq        = w_overlapSlot;
                o_pc_inc_en      = w_capture;
            end
            default: begin
                o_control_reset = 1'b1;
            end
        endcase
    end

    assign io_bus.imem_req       = w_imemReq;
    assign io_bus.fd_instruction = r_fdInstr;
    assign io_bus.fd_valid       = r_fdValid;
    assign o_state               = r_state;
endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer
//   Directed bench for pipeline_sequencer. Two instances share all stimulus:
//   one strict F->D->E (PIPELINED=0) and one overlapped (PIPELINED=1).
module tb_pipeline_sequencer;
    localparam int INSTR_W = 32;
    localparam int EXEC_W  = 2;
    localparam logic [31:0] NOP = 32'hE1A0_0000;

    logic              clk;
    logic              reset;
    logic              stall;
    logic              imemValid;
    logic [31:0]       imemData;
    logic [EXEC_W-1:0] decCycles;
    logic              decWpc;

    int checkCount;
    int passCount;

    logic              pcInc0, decLatch0, exActive0, exLast0, flush0, ctlRst0;
    logic [EXEC_W-1:0] exIdx0;
    logic [1:0]        state0;
    logic              pcInc1, decLatch1, exActive1, exLast1, flush1, ctlRst1;
    logic [EXEC_W-1:0] exIdx1;
    logic [1:0]        state1;

    pipeline_sequencer_if #(.INSTR_W(INSTR_W), .EXEC_W(EXEC_W)) bus0 ();
    pipeline_sequencer_if #(.INSTR_W(INSTR_W), .EXEC_W(EXEC_W)) bus1 ();

    assign bus0.imem_valid      = imemValid;
    assign bus0.imem_data       = imemData;
    assign bus0.dec_exec_cycles = decCycles;
    assign bus0.dec_writes_pc   = decWpc;
    assign bus1.imem_valid      = imemValid;
    assign bus1.imem_data       = imemData;
    assign bus1.dec_exec_cycles = decCycles;
    assign bus1.dec_writes_pc   = decWpc;

    pipeline_sequencer #(
        .INSTR_W(INSTR_W), .EXEC_W(EXEC_W), .RESET_CYCLES(2),
        .NOP_INSTR(NOP), .PIPELINED(0)
    ) u_dut0 (
        .clk(clk), .reset(reset), .i_stall(stall), .io_bus(bus0),
        .o_pc_inc_en(pcInc0), .o_decode_latch(decLatch0),
        .o_exec_active(exActive0), .o_exec_cycle_idx(exIdx0),
        .o_exec_last(exLast0), .o_flush(flush0),
        .o_control_reset(ctlRst0), .o_state(state0)
    );

    pipeline_sequencer #(
        .INSTR_W(INSTR_W), .EXEC_W(EXEC_W), .RESET_CYCLES(2),
        .NOP_INSTR(NOP), .PIPELINED(1)
    ) u_dut1 (
        .clk(clk), .reset(reset), .i_stall(stall), .io_bus(bus1),
        .o_pc_inc_en(pcInc1), .o_decode_latch(decLatch1),
        .o_exec_active(exActive1), .o_exec_cycle_idx(exIdx1),
        .o_exec_last(exLast1), .o_flush(flush1),
        .o_control_reset(ctlRst1), .o_state(state1)
    );

    // Free-running 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive all inputs for the coming edge, then let combinational outputs settle.
    task automatic applyStimulus(input logic rst, input logic valid,
                                 input logic [31:0] data, input logic [EXEC_W-1:0] cyc,
                                 input logic wpc, input logic stl);
        reset     = rst;
        imemValid = valid;
        imemData  = data;
        decCycles = cyc;
        decWpc    = wpc;
        stall     = stl;
        #1;
    endtask

    // Advance one clock; sampling happens 1 unit after the rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;

        // Reset held low for three edges, then released.
        applyStimulus(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
        repeat (3) nextCycle();
        checkOutput("rst_state", 32'(state0), 32'd0);
        checkOutput("rst_ctlrst", 32'(ctlRst0), 32'd1);
        checkOutput("rst_fd", bus0.fd_instruction, NOP);
        checkOutput("rst_fdvalid", 32'(bus0.fd_valid), 32'd0);
        checkOutput("rst_imemreq", 32'(bus0.imem_req), 32'd0);
        checkOutput("rst_exec", 32'(exActive0), 32'd0);

        applyStimulus(1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
        checkOutput("rel0_ctlrst", 32'(ctlRst0), 32'd1);
        nextCycle();
        checkOutput("rel1_ctlrst", 32'(ctlRst0), 32'd1);
        checkOutput("rel1_state", 32'(state0), 32'd0);
        nextCycle();
        checkOutput("rel2_state", 32'(state0), 32'd1);
        checkOutput("rel2_ctlrst", 32'(ctlRst0), 32'd0);
        checkOutput("rel2_imemreq", 32'(bus0.imem_req), 32'd1);
        checkOutput("rel2_fd", bus0.fd_instruction, NOP);

        // Fetch wait states: four cycles without imem_valid, capture on the fifth.
        checkOutput("wait0_pcinc", 32'(pcInc0), 32'd0);
        for (int i = 1; i < 4; i++) begin
            nextCycle();
            checkOutput($sformatf("wait%0d_state", i), 32'(state0), 32'd1);
            checkOutput($sformatf("wait%0d_pcinc", i), 32'(pcInc0), 32'd0);
        end
        nextCycle();
        applyStimulus(1'b1, 1'b1, 32'h1111_1111, 2'd2, 1'b0, 1'b0);
        checkOutput("wait4_pcinc", 32'(pcInc0), 32'd1);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h0, 2'd2, 1'b0, 1'b0);
        checkOutput("cap_state", 32'(state0), 32'd2);
        checkOutput("cap_fd", bus0.fd_instruction, 32'h1111_1111);
        checkOutput("cap_fdvalid", 32'(bus0.fd_valid), 32'd1);
        checkOutput("cap_declatch", 32'(decLatch0), 32'd1);

        // Three-cycle execute with a one-cycle stall on the first cycle.
        nextCycle();
        checkOutput("ex0_idx", 32'(exIdx0), 32'd0);
        checkOutput("ex0_last", 32'(exLast0), 32'd0);
        checkOutput("ex0_active", 32'(exActive0), 32'd1);
        applyStimulus(1'b1, 1'b0, 32'h0, 2'd2, 1'b0, 1'b1);
        nextCycle();
        checkOutput("exstall_state", 32'(state0), 32'd3);
        checkOutput("exstall_idx", 32'(exIdx0), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h0, 2'd2, 1'b0, 1'b0);
        nextCycle();
        checkOutput("ex1_idx", 32'(exIdx0), 32'd1);
        checkOutput("ex1_last", 32'(exLast0), 32'd0);
        nextCycle();
        checkOutput("ex2_idx", 32'(exIdx0), 32'd2);
        checkOutput("ex2_last", 32'(exLast0), 32'd1);
        checkOutput("ex2_req_np", 32'(bus0.imem_req), 32'd0);
        checkOutput("ex2_req_p", 32'(bus1.imem_req), 32'd1);
        nextCycle();
        checkOutput("exdone_state_np", 32'(state0), 32'd1);
        checkOutput("exdone_state_p", 32'(state1), 32'd1);

        // Strict mode, single-cycle execute: one instruction every three cycles.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 32'hA000_0000 + 32'(i), 2'd0, 1'b0, 1'b0);
            checkOutput($sformatf("np%0d_f_state", i), 32'(state0), 32'd1);
            checkOutput($sformatf("np%0d_f_pcinc", i), 32'(pcInc0), 32'd1);
            nextCycle();
            checkOutput($sformatf("np%0d_d_state", i), 32'(state0), 32'd2);
            checkOutput($sformatf("np%0d_d_pcinc", i), 32'(pcInc0), 32'd0);
            checkOutput($sformatf("np%0d_d_fd", i), bus0.fd_instruction, 32'hA000_0000 + 32'(i));
            nextCycle();
            checkOutput($sformatf("np%0d_e_state", i), 32'(state0), 32'd3);
            checkOutput($sformatf("np%0d_e_pcinc", i), 32'(pcInc0), 32'd0);
            nextCycle();
        end

        // Overlapped mode: restart from reset, then run back-to-back ALU ops.
        applyStimulus(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
        nextCycle();
        nextCycle();
        checkOutput("p_fetch_state", 32'(state1), 32'd1);
        applyStimulus(1'b1, 1'b1, 32'hB000_0000, 2'd0, 1'b0, 1'b0);
        checkOutput("p_fetch_pcinc", 32'(pcInc1), 32'd1);
        nextCycle();
        checkOutput("p0_fd", bus1.fd_instruction, 32'hB000_0000);
        for (int i = 1; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 32'hB000_0000 + 32'(i), 2'd0, 1'b0, 1'b0);
            checkOutput($sformatf("p%0d_d_state", i), 32'(state1), 32'd2);
            nextCycle();
            checkOutput($sformatf("p%0d_e_state", i), 32'(state1), 32'd3);
            checkOutput($sformatf("p%0d_e_last", i), 32'(exLast1), 32'd1);
            checkOutput($sformatf("p%0d_e_req", i), 32'(bus1.imem_req), 32'd1);
            checkOutput($sformatf("p%0d_e_pcinc", i), 32'(pcInc1), 32'd1);
            nextCycle();
            checkOutput($sformatf("p%0d_next_state", i), 32'(state1), 32'd2);
            checkOutput($sformatf("p%0d_next_fd", i), bus1.fd_instruction, 32'hB000_0000 + 32'(i));
        end

        // PC-writing two-cycle instruction: flush beats the overlapped fetch.
        applyStimulus(1'b1, 1'b1, 32'hC000_0000, 2'd1, 1'b1, 1'b0);
        nextCycle();
        checkOutput("br_e0_last", 32'(exLast1), 32'd0);
        checkOutput("br_e0_flush", 32'(flush1), 32'd0);
        nextCycle();
        checkOutput("br_e1_idx", 32'(exIdx1), 32'd1);
        checkOutput("br_e1_flush", 32'(flush1), 32'd1);
        checkOutput("br_e1_req", 32'(bus1.imem_req), 32'd0);
        checkOutput("br_e1_pcinc", 32'(pcInc1), 32'd0);
        nextCycle();
        checkOutput("br_after_state", 32'(state1), 32'd1);
        checkOutput("br_after_fdvalid", 32'(bus1.fd_valid), 32'd0);
        checkOutput("br_after_fd", bus1.fd_instruction, NOP);
        checkOutput("br_after_flush", 32'(flush1), 32'd0);

        // Reset asserted in the middle of a four-cycle execute.
        applyStimulus(1'b1, 1'b1, 32'hD000_0000, 2'd3, 1'b0, 1'b0);
        nextCycle();
        nextCycle();
        nextCycle();
        checkOutput("mid_idx", 32'(exIdx1), 32'd1);
        applyStimulus(1'b0, 1'b1, 32'hD000_0000, 2'd3, 1'b0, 1'b0);
        checkOutput("mid_state_pre", 32'(state1), 32'd3);
        nextCycle();
        checkOutput("mid_state_post", 32'(state1), 32'd0);
        checkOutput("mid_ctlrst", 32'(ctlRst1), 32'd1);
        checkOutput("mid_exactive", 32'(exActive1), 32'd0);
        checkOutput("mid_pcinc", 32'(pcInc1), 32'd0);
        checkOutput("mid_imemreq", 32'(bus1.imem_req), 32'd0);
        checkOutput("mid_fdvalid", 32'(bus1.fd_valid), 32'd0);
        checkOutput("mid_fd", bus1.fd_instruction, NOP);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
